// File: rtl/led_pattern_seq.sv
// led_pattern_seq: steps one of four 8-LED display patterns (off, chaser, bounce,
// PWM breathe) on each rising edge of the prescaler's slow square wave.
module led_pattern_seq #(
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_in,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [7:0]          led_out,
  output logic                step_pulse,
  output logic [2:0]          pos,
  output logic [PWM_BITS-1:0] level
);
  localparam logic [PWM_BITS-1:0] LMAX = '1;
  localparam logic [PWM_BITS-1:0] L1 = 1;
  logic                r_tick_q;
  logic [1:0]          r_mode_q;
  logic                r_dir;
  logic [2:0]          r_pos;
  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_pwm;
  logic [7:0]          r_led;
  logic                r_step;
  logic                w_mode_chg;
  logic                w_step;
  logic                w_pos_end;
  logic                w_lvl_end;
  logic [2:0]          w_pos_nxt;
  logic [PWM_BITS-1:0] w_lvl_nxt;
  logic                w_dir_nxt;
  logic [7:0]          w_led;
  // r_dir: 0 = counting up, 1 = counting down; pos and level share the bounce rule
  always_comb begin
    w_mode_chg = mode != r_mode_q;
    w_step     = tick_in & ~r_tick_q & ~pause & ~w_mode_chg & (r_mode_q != 2'd0);
    w_pos_end  = r_dir ? (r_pos == 3'd0) : (r_pos == 3'd7);
    w_lvl_end  = r_dir ? (r_level == '0) : (r_level == LMAX);
    w_pos_nxt  = r_mode_q == 2'd1 ? r_pos + 3'd1 :
                 r_mode_q == 2'd2 ? (w_pos_end ? (r_dir ? 3'd1 : 3'd6) :
                                     (r_dir ? r_pos - 3'd1 : r_pos + 3'd1)) : r_pos;
    w_lvl_nxt  = r_mode_q == 2'd3 ? (w_lvl_end ? (r_dir ? L1 : LMAX - L1) :
                                     (r_dir ? r_level - L1 : r_level + L1)) : r_level;
    w_dir_nxt  = r_mode_q == 2'd2 ? r_dir ^ w_pos_end :
                 r_mode_q == 2'd3 ? r_dir ^ w_lvl_end : r_dir;
    w_led      = r_mode_q == 2'd3 ? {8{r_pwm < r_level}} :
                 r_mode_q == 2'd0 ? 8'h00 : 8'h01 << r_pos;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_q <= 1'b0;
      r_mode_q <= 2'd0;
      r_dir    <= 1'b0;
      r_pos    <= 3'd0;
      r_level  <= '0;
      r_pwm    <= '0;
      r_led    <= 8'h00;
      r_step   <= 1'b0;
    end else begin
      r_tick_q <= tick_in;
      r_mode_q <= mode;
      r_pwm    <= r_pwm + L1;
      r_led    <= w_led;
      r_step   <= w_step;
      if (w_mode_chg) begin
        r_pos   <= 3'd0;
        r_level <= '0;
        r_dir   <= 1'b0;
      end else if (w_step) begin
        r_pos   <= w_pos_nxt;
        r_level <= w_lvl_nxt;
        r_dir   <= w_dir_nxt;
      end
    end
  end
  assign led_out    = r_led;
  assign step_pulse = r_step;
  assign pos        = r_pos;
  assign level      = r_level;
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: scoreboard bench; each issued tick pushes the expected
// pos/level/led, and a monitor pops on every step_pulse.
module tb_led_pattern_seq;
  typedef struct {
    logic [2:0] p;
    logic [3:0] l;
    logic [7:0] led;
    bit         cl;
  } ent_t;
  logic       clk = 0;
  logic       rst = 1;
  logic       tick_in = 0;
  logic [1:0] mode = 2'd1;
  logic       pause = 0;
  logic [7:0] led_out;
  logic       step_pulse;
  logic [2:0] pos;
  logic [3:0] level;
  ent_t       sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_push = 0;
  int         n_steps = 0;

  led_pattern_seq #(.PWM_BITS(4)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .mode(mode), .pause(pause),
    .led_out(led_out), .step_pulse(step_pulse), .pos(pos), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] p, input logic [3:0] l, input bit cl);
    ent_t e;
    e.p = p;
    e.l = l;
    e.led = 8'h01 << p;
    e.cl = cl;
    sb.push_back(e);
    n_push++;
  endtask

  task automatic tick(input int hold);
    @(posedge clk);
    #1 tick_in = 1;
    repeat (hold) @(posedge clk);
    #1 tick_in = 0;
    repeat (3) @(posedge clk);
  endtask

  task automatic duty(input string nm, input int exp);
    int c = 0;
    repeat (16) begin
      @(negedge clk);
      if (led_out == 8'hFF) c++;
    end
    check(nm, c, exp);
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(posedge clk);
    #1 mode = m;
    repeat (3) @(posedge clk);
  endtask

  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (step_pulse) begin
        n_steps++;
        if (sb.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          e = sb.pop_front();
          check("step_pos", pos, e.p);
          check("step_level", level, e.l);
          @(negedge clk);
          check("step_single_cycle", step_pulse, 0);
          if (e.cl) check("step_led", led_out, e.led);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int ct[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
    int bt[16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int lv;
    int k;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 tick_in = ~tick_in;
      @(negedge clk);
      check("rst_led", led_out, 8'h00);
      check("rst_pos", pos, 0);
      check("rst_step", step_pulse, 0);
    end
    tick_in = 0;
    @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    for (int i = 0; i < 9; i++) begin
      push(3'(ct[i]), 4'd0, 1);
      tick(i == 4 ? 50 : 3);
    end
    push(3'd2, 4'd0, 1); tick(3);
    push(3'd3, 4'd0, 1); tick(3);
    #1 pause = 1;
    tick(3);
    tick(3);
    @(negedge clk);
    check("pause_pos", pos, 3);
    pause = 0;
    @(posedge clk);
    #1 mode = 2'd2;
    tick_in = 1;
    repeat (3) @(posedge clk);
    #1 tick_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("modechg_pos", pos, 0);
    check("modechg_led", led_out, 8'h01);
    for (int i = 0; i < 16; i++) begin
      push(3'(bt[i]), 4'd0, 1);
      tick(3);
    end
    set_mode(2'd3);
    @(negedge clk);
    check("breathe_pos0", pos, 0);
    check("breathe_lvl0", level, 0);
    k = 0;
    for (int i = 0; i < 30; i++) begin
      k++;
      lv = k <= 15 ? k : 30 - k;
      push(3'd0, 4'(lv), 0);
      tick(3);
      if (k == 5) begin
        check("lvl5", level, 5);
        duty("duty5", 5);
      end
      if (k == 15) begin
        check("lvl15", level, 15);
        duty("duty15", 15);
      end
    end
    check("lvl30", level, 0);
    duty("duty0", 0);
    for (int i = 1; i <= 9; i++) begin
      push(3'd0, 4'(i), 0);
      tick(3);
    end
    check("lvl9", level, 9);
    k = 0;
    while (k < 32) begin
      @(negedge clk);
      if (led_out == 8'hFF) break;
      k++;
    end
    check("pre_arst_led", led_out, 8'hFF);
    #2 rst = 1;
    #1;
    check("arst_level", level, 0);
    check("arst_led", led_out, 8'h00);
    check("arst_pos", pos, 0);
    check("arst_step", step_pulse, 0);
    repeat (3) @(posedge clk);
    check("sb_empty", sb.size(), 0);
    check("step_count", n_steps, n_push);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
